// File: rtl/pipeline_hazard.sv
// Hazard unit: load-use / RAW stalls, taken-branch flush, operand forwarding selects.
// Optional FORWARD_EN: forward from MEM/WB and stall only on load-use; otherwise stall on any RAW match.
module pipeline_hazard (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  id_rs_a,
  input  logic [1:0]  id_rs_b,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic [1:0]  ex_ra,
  input  logic        ex_reg_en,
  input  logic        ex_is_load,
  input  logic [1:0]  mem_ra,
  input  logic        mem_reg_en,
  input  logic [1:0]  wb_ra,
  input  logic        wb_reg_en,
  input  logic        ex_br_taken,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // state  | meaning
  // RUN    | normal issue, hazards evaluated every cycle
  // LSTALL | cycle after a load-use stall; load result now reachable from MEM
  // FLUSH  | second flush cycle while the PC loads the branch target
  typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t state, state_nxt;

  // hit bit order: [0] EX, [1] MEM, [2] WB
  logic [2:0] hit_a, hit_b;
  logic       load_use, raw_stall;

  assign hit_a[0] = id_use_a && ex_reg_en  && (id_rs_a == ex_ra);
  assign hit_a[1] = id_use_a && mem_reg_en && (id_rs_a == mem_ra);
  assign hit_a[2] = id_use_a && wb_reg_en  && (id_rs_a == wb_ra);
  assign hit_b[0] = id_use_b && ex_reg_en  && (id_rs_b == ex_ra);
  assign hit_b[1] = id_use_b && mem_reg_en && (id_rs_b == mem_ra);
  assign hit_b[2] = id_use_b && wb_reg_en  && (id_rs_b == wb_ra);

  assign load_use = ex_is_load && (hit_a[0] || hit_b[0]);

`ifdef FORWARD_EN
  function automatic logic [1:0] nearest_src(input logic [2:0] hit);
    if (hit[1]) return 2'b01;
    if (hit[2]) return 2'b10;
    return 2'b00;
  endfunction

  assign raw_stall = load_use;
  assign fwd_a_sel = rst ? 2'b00 : nearest_src(hit_a);
  assign fwd_b_sel = rst ? 2'b00 : nearest_src(hit_b);
`else
  assign raw_stall = (|hit_a) || (|hit_b);
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = RUN;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst) begin
      state_nxt = RUN;
    end else if (ex_br_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = FLUSH;
    end else if (state == FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (raw_stall) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
`ifdef FORWARD_EN
      state_nxt    = LSTALL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (if_id_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard.sv
// Bench for pipeline_hazard: vector table, directed corner sequences, random run vs. rule model.
`timescale 1ns/1ps
module tb_pipeline_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_rs_a, id_rs_b, ex_ra, mem_ra, wb_ra;
  logic        id_use_a, id_use_b, ex_reg_en, ex_is_load, mem_reg_en, wb_reg_en, ex_br_taken;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard dut (
    .clk(clk), .rst(rst),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_ra(ex_ra), .ex_reg_en(ex_reg_en), .ex_is_load(ex_is_load),
    .mem_ra(mem_ra), .mem_reg_en(mem_reg_en), .wb_ra(wb_ra), .wb_reg_en(wb_reg_en),
    .ex_br_taken(ex_br_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference state: was the previous cycle a taken branch, and the two event tallies
  bit m_prev_br;
  int m_stall, m_flush;

  typedef struct {
    logic [1:0] rs_a, rs_b;
    logic       use_a, use_b;
    logic [1:0] ex_ra;
    logic       ex_en, ex_ld;
    logic [1:0] mem_ra;
    logic       mem_en;
    logic [1:0] wb_ra;
    logic       wb_en, br;
    logic [3:0] ctl;   // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_a, fwd_b} from the hazard rules.
  function automatic logic [7:0] model_out();
    logic [1:0] ra [3];
    bit en [3];
    bit ha [3], hb [3];
    bit stall, flush;
    logic [1:0] fa, fb;
    if (rst) return 8'h00;
    ra[0] = ex_ra;  ra[1] = mem_ra;  ra[2] = wb_ra;
    en[0] = ex_reg_en; en[1] = mem_reg_en; en[2] = wb_reg_en;
    for (int s = 0; s < 3; s++) begin
      ha[s] = id_use_a && en[s] && (id_rs_a == ra[s]);
      hb[s] = id_use_b && en[s] && (id_rs_b == ra[s]);
    end
    fa = 2'b00;
    fb = 2'b00;
    if (FWD) begin
      if (ha[1]) fa = 2'b01; else if (ha[2]) fa = 2'b10;
      if (hb[1]) fb = 2'b01; else if (hb[2]) fb = 2'b10;
    end
    flush = ex_br_taken || m_prev_br;
    if (FWD) stall = ex_is_load && (ha[0] || hb[0]);
    else     stall = ha[0] || ha[1] || ha[2] || hb[0] || hb[1] || hb[2];
    if (flush) return {4'b0011, fa, fb};
    if (stall) return {4'b1101, fa, fb};
    return {4'b0000, fa, fb};
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit has_exp, input logic [7:0] exp_tbl);
    logic [7:0] exp;
    logic [7:0] act;
    @(negedge clk);
    exp = model_out();
    act = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel};
    check("ctl_fwd", {24'd0, act}, {24'd0, exp});
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
    check("flush_cnt", {16'd0, flush_cnt}, m_flush);
    if (has_exp) check("table", {24'd0, act}, {24'd0, exp_tbl});
    @(posedge clk);
    if (rst) begin
      m_prev_br = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_prev_br = ex_br_taken;
      if (exp[7] && m_stall < 65535) m_stall++;
      if (exp[5] && m_flush < 65535) m_flush++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs_a = 0; id_rs_b = 0; id_use_a = 0; id_use_b = 0;
    ex_ra = 0; ex_reg_en = 0; ex_is_load = 0;
    mem_ra = 0; mem_reg_en = 0; wb_ra = 0; wb_reg_en = 0; ex_br_taken = 0;
  endtask

  task automatic drive(input vec_t v);
    id_rs_a = v.rs_a; id_rs_b = v.rs_b; id_use_a = v.use_a; id_use_b = v.use_b;
    ex_ra = v.ex_ra; ex_reg_en = v.ex_en; ex_is_load = v.ex_ld;
    mem_ra = v.mem_ra; mem_reg_en = v.mem_en; wb_ra = v.wb_ra; wb_reg_en = v.wb_en;
    ex_br_taken = v.br;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  logic [3:0] nf_stall;

  initial begin
    rst = 1'b1;
    m_prev_br = 1'b0;
    m_stall = 0;
    m_flush = 0;
    idle_inputs();
    nf_stall = FWD ? 4'b0000 : 4'b1101;

    //               rs_a rs_b ua ub ex_ra en ld mra men wra wen br  ctl       fa               fb
    tbl[0]  = '{2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 4'b0000, 2'b00, 2'b00};
    tbl[1]  = '{2'd1, 2'd0, 1, 0, 2'd1, 1, 0, 2'd0, 0, 2'd0, 0, 0, nf_stall, 2'b00, 2'b00};
    tbl[2]  = '{2'd2, 2'd0, 1, 0, 2'd0, 0, 0, 2'd2, 1, 2'd0, 0, 0, nf_stall, FWD ? 2'b01 : 2'b00, 2'b00};
    tbl[3]  = '{2'd0, 2'd3, 0, 1, 2'd0, 0, 0, 2'd0, 0, 2'd3, 1, 0, nf_stall, 2'b00, FWD ? 2'b10 : 2'b00};
    tbl[4]  = '{2'd0, 2'd1, 0, 1, 2'd0, 0, 0, 2'd1, 1, 2'd1, 1, 0, nf_stall, 2'b00, FWD ? 2'b01 : 2'b00};
    tbl[5]  = '{2'd2, 2'd0, 0, 0, 2'd0, 0, 0, 2'd2, 1, 2'd0, 0, 0, 4'b0000, 2'b00, 2'b00};
    tbl[6]  = '{2'd2, 2'd0, 1, 0, 2'd0, 0, 0, 2'd2, 0, 2'd2, 0, 0, 4'b0000, 2'b00, 2'b00};
    tbl[7]  = '{2'd0, 2'd0, 0, 1, 2'd0, 1, 1, 2'd0, 0, 2'd0, 0, 0, 4'b1101, 2'b00, 2'b00};
    tbl[8]  = '{2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 4'b0000, 2'b00, 2'b00};
    tbl[9]  = '{2'd2, 2'd0, 1, 0, 2'd2, 1, 1, 2'd0, 0, 2'd0, 0, 1, 4'b0011, 2'b00, 2'b00};
    tbl[10] = '{2'd2, 2'd0, 1, 0, 2'd2, 1, 1, 2'd0, 0, 2'd0, 0, 0, 4'b0011, 2'b00, 2'b00};
    tbl[11] = '{2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 4'b0000, 2'b00, 2'b00};

    // reset state with hostile inputs: everything must read 0
    ex_br_taken = 1; id_use_a = 1; ex_reg_en = 1; ex_is_load = 1; mem_reg_en = 1;
    step(1'b1, 8'h00);
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step(1'b1, {tbl[i].ctl, tbl[i].fa, tbl[i].fb});
    end

    // branch concurrent with load-use: flush on N and N+1, never stall
    do_reset();
    id_rs_a = 2; id_use_a = 1; ex_ra = 2; ex_reg_en = 1; ex_is_load = 1; ex_br_taken = 1;
    step(1'b1, 8'b0011_0000);
    ex_br_taken = 0;
    step(1'b1, 8'b0011_0000);
    check("br_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    check("br_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    do_reset();
`ifdef FORWARD_EN
    // load-use: one stall, then the load forwards from MEM
    id_rs_a = 2; id_use_a = 1; ex_ra = 2; ex_reg_en = 1; ex_is_load = 1;
    step(1'b1, 8'b1101_0000);
    ex_reg_en = 0; ex_is_load = 0; mem_ra = 2; mem_reg_en = 1;
    step(1'b1, 8'b0000_0100);
    check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
`else
    // non-load write to r3 followed by a reader: stall through EX, MEM, WB
    id_rs_a = 3; id_use_a = 1; ex_ra = 3; ex_reg_en = 1;
    step(1'b1, 8'b1101_0000);
    ex_reg_en = 0; mem_ra = 3; mem_reg_en = 1;
    step(1'b1, 8'b1101_0000);
    mem_reg_en = 0; wb_ra = 3; wb_reg_en = 1;
    step(1'b1, 8'b1101_0000);
    wb_reg_en = 0;
    step(1'b1, 8'b0000_0000);
    check("raw_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // reset during FLUSH abandons it
    do_reset();
    ex_br_taken = 1;
    step(1'b1, 8'b0011_0000);
    rst = 1; id_rs_a = 1; id_use_a = 1; ex_ra = 1; ex_reg_en = 1; ex_is_load = 1;
    step(1'b1, 8'h00);
    rst = 0;
    idle_inputs();
    check("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    step(1'b1, 8'h00);

    // stall counter saturation under a persistent load-use match
    do_reset();
    id_rs_a = 1; id_use_a = 1; ex_ra = 1; ex_reg_en = 1; ex_is_load = 1;
    for (int i = 0; i < 65540; i++) step(1'b0, 8'h00);
    check("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    step(1'b0, 8'h00);
    check("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

    // random traffic against the rule model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_rs_a     = 2'($urandom_range(0, 3));
      id_rs_b     = 2'($urandom_range(0, 3));
      id_use_a    = 1'($urandom_range(0, 1));
      id_use_b    = 1'($urandom_range(0, 1));
      ex_ra       = 2'($urandom_range(0, 3));
      ex_reg_en   = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      mem_ra      = 2'($urandom_range(0, 3));
      mem_reg_en  = 1'($urandom_range(0, 1));
      wb_ra       = 2'($urandom_range(0, 3));
      wb_reg_en   = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 5) == 0);
      step(1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
